// File: rtl/cc_posregister_jug2.sv
// Player-2 horizontal position register: one-hot bus moved left/right by
// held buttons, with a first-step/auto-repeat hold timer and edge saturation.
module cc_posregister_jug2 #(
   parameter int PosREGISTER_DATAWIDTH = 8,
   parameter int INIT_POS              = 3,
   parameter int DELAY_FIRST           = 25000000,
   parameter int DELAY_REPEAT          = 10000000,
   parameter int CNT_WIDTH             = 25
) (
   input  logic                             CC_RegPOSJUG2_CLOCK_50,
   input  logic                             CC_RegPOSJUG2_RESET_InHigh,
   input  logic                             CC_RegPOSJUG2_enable_InHigh,
   input  logic                             CC_RegPOSJUG2_clear_InHigh,
   input  logic                             CC_RegPOSJUG2_left_InHigh,
   input  logic                             CC_RegPOSJUG2_right_InHigh,
   output logic [PosREGISTER_DATAWIDTH-1:0] CC_RegPOSJUG2_posjug2_OutBUS,
   output logic                             CC_RegPOSJUG2_move_OutHigh,
   output logic                             CC_RegPOSJUG2_atleft_OutHigh,
   output logic                             CC_RegPOSJUG2_atright_OutHigh
);

   localparam int W = PosREGISTER_DATAWIDTH;
   localparam logic [W-1:0]         INIT_BUS = W'(1) << INIT_POS;
   localparam logic [CNT_WIDTH-1:0] LIM_FIRST  = CNT_WIDTH'(DELAY_FIRST - 1);
   localparam logic [CNT_WIDTH-1:0] LIM_REPEAT = CNT_WIDTH'(DELAY_REPEAT - 1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      HOLD_FIRST  = 2'd1,
      HOLD_REPEAT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   dir_q, dir_d;      // 1 = left (toward MSB), 0 = right
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [W-1:0]           pos_q, pos_d;
   logic                   move_q, move_d;

   logic                   left, right;
   logic                   held, other;
   logic [W-1:0]           pos_left, pos_right;
   logic [CNT_WIDTH-1:0]   lim;

   assign left  = CC_RegPOSJUG2_left_InHigh;
   assign right = CC_RegPOSJUG2_right_InHigh;
   assign held  = dir_q ? left : right;
   assign other = dir_q ? right : left;
   assign lim   = (state_q == HOLD_REPEAT) ? LIM_REPEAT : LIM_FIRST;

   // Saturating shifts: at an edge the shifted value is simply the current one.
   assign pos_left  = pos_q[W-1] ? pos_q : (pos_q << 1);
   assign pos_right = pos_q[0]   ? pos_q : (pos_q >> 1);

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      move_d  = 1'b0;
      if (CC_RegPOSJUG2_clear_InHigh) begin
         state_d = IDLE;
         dir_d   = 1'b0;
         cnt_d   = '0;
         pos_d   = INIT_BUS;
      end else if (!CC_RegPOSJUG2_enable_InHigh) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (left ^ right) begin
                  pos_d   = left ? pos_left : pos_right;
                  move_d  = (pos_d != pos_q);
                  dir_d   = left;
                  cnt_d   = '0;
                  state_d = HOLD_FIRST;
               end
            end
            HOLD_FIRST, HOLD_REPEAT: begin
               if (held && !other) begin
                  if (cnt_q == lim) begin
                     pos_d   = dir_q ? pos_left : pos_right;
                     move_d  = (pos_d != pos_q);
                     cnt_d   = '0;
                     state_d = HOLD_REPEAT;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CC_RegPOSJUG2_CLOCK_50) begin
      if (CC_RegPOSJUG2_RESET_InHigh) begin
         state_q <= IDLE;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         pos_q   <= INIT_BUS;
         move_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         move_q  <= move_d;
      end
   end

   assign CC_RegPOSJUG2_posjug2_OutBUS  = pos_q;
   assign CC_RegPOSJUG2_move_OutHigh    = move_q;
   assign CC_RegPOSJUG2_atleft_OutHigh  = pos_q[W-1];
   assign CC_RegPOSJUG2_atright_OutHigh = pos_q[0];

endmodule

// File: tb/tb_cc_posregister_jug2.sv
// Directed bench for cc_posregister_jug2 with short hold delays (first 4, repeat 2).
module tb_cc_posregister_jug2;

   logic       clk = 1'b0;
   logic       rst, en, clr, left, right;
   logic [7:0] bus;
   logic       move, atleft, atright;
   int         checks = 0;
   int         errors = 0;

   cc_posregister_jug2 #(
      .PosREGISTER_DATAWIDTH(8),
      .INIT_POS(3),
      .DELAY_FIRST(4),
      .DELAY_REPEAT(2),
      .CNT_WIDTH(3)
   ) dut (
      .CC_RegPOSJUG2_CLOCK_50(clk),
      .CC_RegPOSJUG2_RESET_InHigh(rst),
      .CC_RegPOSJUG2_enable_InHigh(en),
      .CC_RegPOSJUG2_clear_InHigh(clr),
      .CC_RegPOSJUG2_left_InHigh(left),
      .CC_RegPOSJUG2_right_InHigh(right),
      .CC_RegPOSJUG2_posjug2_OutBUS(bus),
      .CC_RegPOSJUG2_move_OutHigh(move),
      .CC_RegPOSJUG2_atleft_OutHigh(atleft),
      .CC_RegPOSJUG2_atright_OutHigh(atright)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle; outputs then reflect that edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; clr = 1'b0; left = 1'b0; right = 1'b0;
      tick(); tick();
      checks++; if (bus !== 8'h08) begin errors++; $display("FAIL reset_bus got %h want 08", bus); end
      checks++; if (move !== 1'b0) begin errors++; $display("FAIL reset_move got %b want 0", move); end
      checks++; if ({atleft, atright} !== 2'b00) begin errors++; $display("FAIL reset_edges got %b want 00", {atleft, atright}); end
      rst = 1'b0;
      tick();
      checks++; if (bus !== 8'h08 || move !== 1'b0) begin errors++; $display("FAIL reset_idle got %h/%b want 08/0", bus, move); end
      $display("test_reset: bus=%h move=%b", bus, move);
   endtask

   task automatic test_right_hold;
      logic [7:0] eb [9] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01};
      logic       em [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      right = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         checks++;
         if (bus !== eb[i] || move !== em[i]) begin
            errors++; $display("FAIL right_hold edge k+%0d got %h/%b want %h/%b", i, bus, move, eb[i], em[i]);
         end
      end
      checks++; if (atright !== 1'b1 || atleft !== 1'b0) begin errors++; $display("FAIL right_edge got %b%b want 01", atleft, atright); end
      $display("test_right_hold: bus=%h atright=%b", bus, atright);
      right = 1'b0; tick();
      clr = 1'b1; tick();
      checks++; if (bus !== 8'h08 || move !== 1'b0) begin errors++; $display("FAIL clear_no_move got %h/%b want 08/0", bus, move); end
      clr = 1'b0;
   endtask

   task automatic test_left_hold;
      logic [7:0] eb [11] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80};
      logic       em [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      left = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick();
         checks++;
         if (bus !== eb[i] || move !== em[i]) begin
            errors++; $display("FAIL left_hold edge k+%0d got %h/%b want %h/%b", i, bus, move, eb[i], em[i]);
         end
      end
      checks++; if (atleft !== 1'b1 || atright !== 1'b0) begin errors++; $display("FAIL left_edge got %b%b want 10", atleft, atright); end
      $display("test_left_hold: bus=%h atleft=%b", bus, atleft);
      left = 1'b0; tick();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic test_left_tap;
      left = 1'b1; tick(); left = 1'b0;
      checks++; if (bus !== 8'h10 || move !== 1'b1) begin errors++; $display("FAIL tap_step got %h/%b want 10/1", bus, move); end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (bus !== 8'h10 || move !== 1'b0) begin errors++; $display("FAIL tap_no_repeat cyc %0d got %h/%b want 10/0", i, bus, move); end
      end
      $display("test_left_tap: bus=%h", bus);
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic test_both;
      left = 1'b1; right = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (bus !== 8'h08 || move !== 1'b0) begin errors++; $display("FAIL both_held cyc %0d got %h/%b want 08/0", i, bus, move); end
      end
      $display("test_both: bus=%h", bus);
      left = 1'b0; right = 1'b0; tick();
   endtask

   task automatic test_reverse;
      right = 1'b1;
      for (int i = 0; i < 5; i++) tick();   // edges k..k+4, now HOLD_REPEAT at 02
      checks++; if (bus !== 8'h02 || move !== 1'b1) begin errors++; $display("FAIL rev_setup got %h/%b want 02/1", bus, move); end
      right = 1'b0; left = 1'b1;
      tick();
      checks++; if (bus !== 8'h02 || move !== 1'b0) begin errors++; $display("FAIL rev_exit got %h/%b want 02/0", bus, move); end
      tick();
      checks++; if (bus !== 8'h04 || move !== 1'b1) begin errors++; $display("FAIL rev_step got %h/%b want 04/1", bus, move); end
      $display("test_reverse: bus=%h", bus);
      left = 1'b0; tick();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic test_clear_enable;
      right = 1'b1; tick(); tick();
      checks++; if (bus !== 8'h04) begin errors++; $display("FAIL ce_setup got %h want 04", bus); end
      clr = 1'b1; tick(); clr = 1'b0; en = 1'b0;
      checks++; if (bus !== 8'h08 || move !== 1'b0) begin errors++; $display("FAIL ce_clear got %h/%b want 08/0", bus, move); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus !== 8'h08 || move !== 1'b0) begin errors++; $display("FAIL ce_disabled cyc %0d got %h/%b want 08/0", i, bus, move); end
      end
      en = 1'b1; tick();
      checks++; if (bus !== 8'h04 || move !== 1'b1) begin errors++; $display("FAIL ce_resume got %h/%b want 04/1", bus, move); end
      $display("test_clear_enable: bus=%h", bus);
      right = 1'b0; tick();
   endtask

   task automatic test_reset_midhold;
      right = 1'b1; tick(); right = 1'b0;
      checks++; if (bus !== 8'h02 || move !== 1'b1) begin errors++; $display("FAIL rm_setup got %h/%b want 02/1", bus, move); end
      right = 1'b1; tick();                 // HOLD_FIRST, counter advancing
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (bus !== 8'h08 || move !== 1'b0) begin errors++; $display("FAIL rm_reset got %h/%b want 08/0", bus, move); end
      tick();
      checks++; if (bus !== 8'h04 || move !== 1'b1) begin errors++; $display("FAIL rm_repress got %h/%b want 04/1", bus, move); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus !== 8'h04 || move !== 1'b0) begin errors++; $display("FAIL rm_counter cyc %0d got %h/%b want 04/0", i, bus, move); end
      end
      tick();
      checks++; if (bus !== 8'h02 || move !== 1'b1) begin errors++; $display("FAIL rm_first_repeat got %h/%b want 02/1", bus, move); end
      $display("test_reset_midhold: bus=%h", bus);
      right = 1'b0; tick();
   endtask

   initial begin
      test_reset();
      test_right_hold();
      test_left_hold();
      test_left_tap();
      test_both();
      test_reverse();
      test_clear_enable();
      test_reset_midhold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
